// File: rtl/addsub_share_ctrl.sv
// Round-robin arbiter that time-shares one external add/subtract datapath between
// NUM_REQ requesters: grant, drive registered operands, capture result and flags, respond.
module addsub_share_ctrl #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic                     dp_sub,
  input  logic [WIDTH-1:0]         dp_result,
  input  logic                     dp_carry,
  input  logic                     dp_overflow,
  input  logic                     dp_negative,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_carry,
  output logic                     resp_overflow,
  output logic                     resp_negative,
  output logic                     resp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic              dp_sub_q, dp_sub_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_result_q, resp_result_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_overflow_q, resp_overflow_d;
  logic              resp_negative_q, resp_negative_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_valid_q, resp_valid_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sel_sub;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_sub = req_sub[i];
      end
    end
  end

  // Ready is forced low while reset is held so every output reads zero in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    dp_a_d          = dp_a_q;
    dp_b_d          = dp_b_q;
    dp_sub_d        = dp_sub_q;
    resp_id_d       = resp_id_q;
    resp_result_d   = resp_result_q;
    resp_carry_d    = resp_carry_q;
    resp_overflow_d = resp_overflow_q;
    resp_negative_d = resp_negative_q;
    resp_zero_d     = resp_zero_q;
    resp_valid_d    = resp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          dp_a_d    = sel_a;
          dp_b_d    = sel_b;
          dp_sub_d  = sel_sub;
          resp_id_d = grant_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        resp_result_d   = dp_result;
        resp_carry_d    = dp_carry;
        resp_overflow_d = dp_overflow;
        resp_negative_d = dp_negative;
        resp_zero_d     = (dp_result == '0);
        resp_valid_d    = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      dp_a_q          <= '0;
      dp_b_q          <= '0;
      dp_sub_q        <= 1'b0;
      resp_id_q       <= '0;
      resp_result_q   <= '0;
      resp_carry_q    <= 1'b0;
      resp_overflow_q <= 1'b0;
      resp_negative_q <= 1'b0;
      resp_zero_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      dp_a_q          <= dp_a_d;
      dp_b_q          <= dp_b_d;
      dp_sub_q        <= dp_sub_d;
      resp_id_q       <= resp_id_d;
      resp_result_q   <= resp_result_d;
      resp_carry_q    <= resp_carry_d;
      resp_overflow_q <= resp_overflow_d;
      resp_negative_q <= resp_negative_d;
      resp_zero_q     <= resp_zero_d;
      resp_valid_q    <= resp_valid_d;
    end
  end

  assign dp_a          = dp_a_q;
  assign dp_b          = dp_b_q;
  assign dp_sub        = dp_sub_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_carry    = resp_carry_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_negative = resp_negative_q;
  assign resp_zero     = resp_zero_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: supplies the shared add/sub datapath, runs directed
// scenarios with literal expectations, and checks every cycle against a transaction model.
module tb_addsub_share_ctrl;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sub = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [W-1:0]   dp_a, dp_b;
  logic           dp_sub;
  logic [W-1:0]   dp_result;
  logic           dp_carry, dp_overflow, dp_negative;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_result;
  logic           resp_carry, resp_overflow, resp_negative, resp_zero;
  logic [4:0]     dpSum;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  addsub_share_ctrl #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub),
    .dp_result(dp_result), .dp_carry(dp_carry),
    .dp_overflow(dp_overflow), .dp_negative(dp_negative),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .resp_overflow(resp_overflow), .resp_negative(resp_negative),
    .resp_zero(resp_zero)
  );

  // Shared arithmetic unit: subtraction is A + ~B + 1, carry is the adder carry-out.
  always_comb begin
    dpSum = dp_sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 5'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
    dp_result   = dpSum[3:0];
    dp_carry    = dpSum[4];
    dp_overflow = dp_sub ? ((dp_a[3] != dp_b[3]) && (dpSum[3] != dp_a[3]))
                         : ((dp_a[3] == dp_b[3]) && (dpSum[3] != dp_a[3]));
    dp_negative = dp_sub ? (dp_a < dp_b) : dpSum[3];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Integer-level view of what the datapath should return for one operation.
  function automatic void expectOp(input int a, input int b, input bit sub,
                                   output int res, output bit c, output bit v,
                                   output bit n, output bit z);
    int sa, sb, u, s;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    n = 1'b0;
    if (sub) begin
      u = a - b; s = sa - sb; c = (a >= b); n = (a < b);
    end else begin
      u = a + b; s = sa + sb; c = (u >= 16);
    end
    res = (u + 16) % 16;
    if (!sub) n = (res >= 8);
    v = (s > 7) || (s < -8);
    z = (res == 0);
  endfunction

  function automatic logic [N-1:0] grantFor(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) begin
        g[(ptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int oneHotIdx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction model: idle -> accepted op -> result one cycle later -> held until taken.
  initial begin : compare
    bit busy;
    int age, rrPtr, curId, curA, curB, eRes;
    bit curSub, eC, eV, eN, eZ;
    logic [N-1:0] expReady;
    logic [N*W-1:0] shifted;
    busy = 0; age = 0; rrPtr = 0; curId = 0; curA = 0; curB = 0; curSub = 0;
    eRes = 0; eC = 0; eV = 0; eN = 0; eZ = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; rrPtr = 0;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_dp_a", dp_a, 0);
        checkOutput("rst_dp_b", dp_b, 0);
        checkOutput("rst_dp_sub", dp_sub, 0);
        checkOutput("rst_resp_id", resp_id, 0);
        checkOutput("rst_resp_result", resp_result, 0);
        checkOutput("rst_resp_flags", {resp_carry, resp_overflow, resp_negative, resp_zero}, 0);
      end else if (!busy) begin
        expReady = grantFor(req_valid, rrPtr);
        checkOutput("mdl_req_ready", req_ready, expReady);
        checkOutput("mdl_idle_valid", resp_valid, 0);
        if (expReady != '0) begin
          curId = oneHotIdx(expReady);
          shifted = req_a >> (W * curId);
          curA = int'(shifted[W-1:0]);
          shifted = req_b >> (W * curId);
          curB = int'(shifted[W-1:0]);
          curSub = req_sub[curId];
          expectOp(curA, curB, curSub, eRes, eC, eV, eN, eZ);
          busy = 1; age = 0;
        end
      end else begin
        age++;
        checkOutput("mdl_busy_ready", req_ready, 0);
        checkOutput("mdl_dp_a", dp_a, curA);
        checkOutput("mdl_dp_b", dp_b, curB);
        checkOutput("mdl_dp_sub", dp_sub, curSub);
        if (age == 1) begin
          checkOutput("mdl_exec_valid", resp_valid, 0);
        end else begin
          checkOutput("mdl_resp_valid", resp_valid, 1);
          checkOutput("mdl_resp_id", resp_id, curId);
          checkOutput("mdl_resp_result", resp_result, eRes);
          checkOutput("mdl_resp_flags", {resp_carry, resp_overflow, resp_negative, resp_zero},
                      {eC, eV, eN, eZ});
          if (resp_ready) begin
            busy = 0;
            rrPtr = (curId + 1) % N;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] sub,
                               input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic rdy);
    req_valid = valid; req_sub = sub; req_a = a; req_b = b; resp_ready = rdy;
  endtask

  task automatic setReq(input int i, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
    req_sub[i] = sub; req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1;
  endtask

  task automatic waitGrant(input string name, output int id);
    id = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        id = oneHotIdx(req_ready);
        break;
      end
    end
    if (id < 0) checkOutput({name, "_grant_timeout"}, 0, 1);
  endtask

  task automatic waitRespValid(input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput({name, "_resp_timeout"}, 0, 1);
  endtask

  // One request from requester i, accepted and drained with resp_ready held high.
  task automatic runSingle(input string name, input int i, input bit sub,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expRes, input logic [3:0] expFlags);
    int id;
    setReq(i, sub, a, b);
    waitGrant(name, id);
    checkOutput({name, "_grant"}, id, i);
    @(posedge clk); #1 req_valid[i] = 1'b0;
    @(negedge clk);
    checkOutput({name, "_exec_valid"}, resp_valid, 0);
    @(negedge clk);
    checkOutput({name, "_valid"}, resp_valid, 1);
    checkOutput({name, "_id"}, resp_id, i);
    checkOutput({name, "_result"}, resp_result, expRes);
    checkOutput({name, "_cvnz"}, {resp_carry, resp_overflow, resp_negative, resp_zero}, expFlags);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int id;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    applyStimulus('0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b1;

    $display("[TB] add with carry out");
    runSingle("s1", 0, 1'b0, 4'b0101, 4'b1100, 4'b0001, 4'b1000);

    $display("[TB] subtract negative, then zero, then signed add overflow");
    runSingle("s2a", 2, 1'b1, 4'b0001, 4'b0010, 4'b1111, 4'b0010);
    runSingle("s2b", 2, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1001);
    runSingle("s2c", 3, 1'b0, 4'b0111, 4'b0001, 4'b1000, 4'b0110);

    $display("[TB] all requesters valid, rotation");
    applyStimulus(4'b1111, 4'b1010, {4'd4, 4'd3, 4'd2, 4'd1}, {4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      waitGrant("s3", id);
      checkOutput($sformatf("s3_order%0d", k), id, order[k]);
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] pointer at 2 with requesters 1 and 3");
    runSingle("s4a", 1, 1'b0, 4'd3, 4'd4, 4'd7, 4'b0000);
    setReq(1, 1'b0, 4'd1, 4'd1);
    setReq(3, 1'b0, 4'd2, 4'd2);
    waitGrant("s4b", id);
    checkOutput("s4_first", id, 3);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    waitGrant("s4c", id);
    checkOutput("s4_second", id, 1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] response stall");
    resp_ready = 1'b0;
    setReq(0, 1'b1, 4'd9, 4'd3);
    waitGrant("s5", id);
    checkOutput("s5_grant", id, 0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    setReq(2, 1'b0, 4'd1, 4'd2);
    waitRespValid("s5");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("s5_hold_valid%0d", k), resp_valid, 1);
      checkOutput($sformatf("s5_hold_result%0d", k), resp_result, 4'd6);
      checkOutput($sformatf("s5_hold_cvnz%0d", k),
                  {resp_carry, resp_overflow, resp_negative, resp_zero}, 4'b1100);
      checkOutput($sformatf("s5_hold_ready%0d", k), req_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("s5_after_ready", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;

    $display("[TB] reset during execute");
    setReq(1, 1'b0, 4'd2, 4'd2);
    waitGrant("s6", id);
    checkOutput("s6_grant", id, 1);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_dp_a", dp_a, 0);
    checkOutput("s6_rst_resp_id", resp_id, 0);
    checkOutput("s6_rst_valid", resp_valid, 0);
    req_valid = 4'b0011;
    @(negedge clk);
    checkOutput("s6_rst_ready", req_ready, 0);
    req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    setReq(0, 1'b0, 4'd5, 4'd5);
    setReq(1, 1'b1, 4'd5, 4'd6);
    waitGrant("s6a", id);
    checkOutput("s6_first", id, 0);
    checkOutput("s6_no_stale", resp_valid, 0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    waitGrant("s6b", id);
    checkOutput("s6_second", id, 1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
